// File: rtl/rl_particle_cache_loader.sv
// Write side of the home/neighbor particle position RAMs: streams a home cell then a
// neighbor cell into the x/y/z RAMs, then starts the LJ evaluation unit and waits for done.

module rl_cell_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM        = 100,
  parameter int AW         = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [DATA_WIDTH-1:0] z,
  output logic                  wren,
  output logic [AW-1:0]         wraddr,
  output logic [DATA_WIDTH-1:0] wrdata_x,
  output logic [DATA_WIDTH-1:0] wrdata_y,
  output logic [DATA_WIDTH-1:0] wrdata_z,
  output logic [AW:0]           count,
  output logic                  drop
);
  localparam logic [AW:0] MAX = (AW+1)'(NUM);

  logic room;
  assign room = (count < MAX);
  // a word for a full cell is discarded; the caller latches the sticky error
  assign drop = wr_req & ~room;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wren     <= 1'b0;
      wraddr   <= '0;
      wrdata_x <= '0;
      wrdata_y <= '0;
      wrdata_z <= '0;
      count    <= '0;
    end else begin
      wren <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (wr_req && room) begin
        wren     <= 1'b1;
        wraddr   <= count[AW-1:0];
        wrdata_x <= x;
        wrdata_y <= y;
        wrdata_z <= z;
        count    <= count + (AW+1)'(1);
      end
    end
  end
endmodule

module rl_particle_cache_loader #(
  parameter int DATA_WIDTH              = 32,
  parameter int REF_PARTICLE_NUM        = 100,
  parameter int REF_RAM_ADDR_WIDTH      = 7,
  parameter int NEIGHBOR_PARTICLE_NUM   = 100,
  parameter int NEIGHBOR_RAM_ADDR_WIDTH = 7
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_req,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              in_x,
  input  logic [DATA_WIDTH-1:0]              in_y,
  input  logic [DATA_WIDTH-1:0]              in_z,
  input  logic                               in_last,
  output logic                               ref_wren,
  output logic [REF_RAM_ADDR_WIDTH-1:0]      ref_wraddr,
  output logic [DATA_WIDTH-1:0]              ref_wrdata_x,
  output logic [DATA_WIDTH-1:0]              ref_wrdata_y,
  output logic [DATA_WIDTH-1:0]              ref_wrdata_z,
  output logic                               neighbor_wren,
  output logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] neighbor_wraddr,
  output logic [DATA_WIDTH-1:0]              neighbor_wrdata_x,
  output logic [DATA_WIDTH-1:0]              neighbor_wrdata_y,
  output logic [DATA_WIDTH-1:0]              neighbor_wrdata_z,
  output logic                               eval_start,
  input  logic                               eval_done,
  output logic [REF_RAM_ADDR_WIDTH:0]        ref_count,
  output logic [NEIGHBOR_RAM_ADDR_WIDTH:0]   neighbor_count,
  output logic                               busy,
  output logic                               overflow_err
);
  typedef enum logic [2:0] {IDLE, LOAD_REF, LOAD_NBR, START_EVAL, WAIT_DONE} state_t;

  state_t state, state_nxt;
  logic   hs, clear, drop_ref, drop_nbr;

  assign hs       = in_valid & in_ready;
  assign clear    = (state == IDLE) & load_req;
  assign in_ready = (state == LOAD_REF) | (state == LOAD_NBR);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (load_req)        state_nxt = LOAD_REF;
      LOAD_REF:   if (hs && in_last)   state_nxt = LOAD_NBR;
      LOAD_NBR:   if (hs && in_last)   state_nxt = START_EVAL;
      START_EVAL:                      state_nxt = WAIT_DONE;
      WAIT_DONE:  if (eval_done)       state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // eval_start is registered out of START_EVAL so it trails the final RAM write by a cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      eval_start   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      eval_start <= (state == START_EVAL);
      if (clear)                     overflow_err <= 1'b0;
      else if (drop_ref || drop_nbr) overflow_err <= 1'b1;
    end
  end

  rl_cell_writer #(.DATA_WIDTH(DATA_WIDTH), .NUM(REF_PARTICLE_NUM), .AW(REF_RAM_ADDR_WIDTH)) u_ref (
    .clk(clk), .rst(rst), .clear(clear), .wr_req(hs && (state == LOAD_REF)),
    .x(in_x), .y(in_y), .z(in_z),
    .wren(ref_wren), .wraddr(ref_wraddr),
    .wrdata_x(ref_wrdata_x), .wrdata_y(ref_wrdata_y), .wrdata_z(ref_wrdata_z),
    .count(ref_count), .drop(drop_ref)
  );

  rl_cell_writer #(.DATA_WIDTH(DATA_WIDTH), .NUM(NEIGHBOR_PARTICLE_NUM), .AW(NEIGHBOR_RAM_ADDR_WIDTH)) u_nbr (
    .clk(clk), .rst(rst), .clear(clear), .wr_req(hs && (state == LOAD_NBR)),
    .x(in_x), .y(in_y), .z(in_z),
    .wren(neighbor_wren), .wraddr(neighbor_wraddr),
    .wrdata_x(neighbor_wrdata_x), .wrdata_y(neighbor_wrdata_y), .wrdata_z(neighbor_wrdata_z),
    .count(neighbor_count), .drop(drop_nbr)
  );
endmodule
